// File: rtl/fill_rect_gen_engine_p.sv
// fill_rect_gen_engine_p: streams solid or outline rectangle fills as per-channel byte writes to an arbiter.
// Ports: clk/rst_ (async active-low); start_strobe + init_addr/cmd_hgt/cmd_wid/cmd_{r,g,b}val/cmd_mode
// command; busy/done status; arb_out_rts/arb_in_rtr handshake with arb_out_op/addr/wben/data request.
module fill_rect_gen_engine_p #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 16,
    parameter int STRIDE = 240
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start_strobe,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DIM_W-1:0]  cmd_hgt,
    input  logic [DIM_W-1:0]  cmd_wid,
    input  logic [3:0]        cmd_rval,
    input  logic [3:0]        cmd_gval,
    input  logic [3:0]        cmd_bval,
    input  logic              cmd_mode,
    output logic              busy,
    output logic              done,
    output logic              arb_out_rts,
    input  logic              arb_in_rtr,
    output logic              arb_out_op,
    output logic [ADDR_W-1:0] arb_out_addr,
    output logic [3:0]        arb_out_wben,
    output logic [31:0]       arb_out_data
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0] row, col, hgt, wid, col_grp;
    logic [1:0] ch;
    logic [3:0] rval, gval, bval, v;
    logic mode, xfc, last_col, last_row, edge_row, pix_done, launch;

    assign launch   = state == IDLE && start_strobe;
    assign xfc      = arb_out_rts & arb_in_rtr;
    assign last_col = col == wid - DIM_W'(1);
    assign last_row = row == hgt - DIM_W'(1);
    assign edge_row = row == '0 || last_row;
    assign pix_done = xfc && ch == 2'd2;
    assign col_grp  = col >> 2;
    assign v        = ch == 2'd0 ? rval : ch == 2'd1 ? gval : bval;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !start_strobe ? IDLE : (cmd_hgt == '0 || cmd_wid == '0) ? DONE : DRIVE;
            DRIVE:   state_n = (pix_done && last_col && last_row) ? DONE : DRIVE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields are pure functions of held registers, so they stay put while stalled;
    // they are forced to zero whenever no request is offered.
    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign arb_out_rts  = state == DRIVE;
    assign arb_out_op   = 1'b1;
    assign arb_out_addr = arb_out_rts ? row_base + ADDR_W'(col_grp) * ADDR_W'(3) + ADDR_W'(ch) : '0;
    assign arb_out_wben = arb_out_rts ? 4'b0001 << col[1:0] : '0;
    assign arb_out_data = arb_out_rts ? {24'd0, v, v} << {col[1:0], 3'b000} : '0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            row_base <= '0;
            row      <= '0;
            col      <= '0;
            ch       <= '0;
            hgt      <= '0;
            wid      <= '0;
            rval     <= '0;
            gval     <= '0;
            bval     <= '0;
            mode     <= 1'b0;
        end else begin
            state <= state_n;
            if (launch) begin
                row_base <= init_addr;
                hgt      <= cmd_hgt;
                wid      <= cmd_wid;
                rval     <= cmd_rval;
                gval     <= cmd_gval;
                bval     <= cmd_bval;
                mode     <= cmd_mode;
                row      <= '0;
                col      <= '0;
                ch       <= '0;
            end else if (xfc) begin
                ch <= pix_done ? 2'd0 : ch + 2'd1;
                if (pix_done && last_col && !last_row) begin
                    row      <= row + DIM_W'(1);
                    col      <= '0;
                    row_base <= row_base + ADDR_W'(STRIDE);
                end else if (pix_done && !last_col) begin
                    // Outline interior rows only touch the two side columns.
                    col <= (mode && !edge_row && col == '0) ? wid - DIM_W'(1) : col + DIM_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fill_rect_gen_engine_p.sv
// tb_fill_rect_gen_engine_p: directed self-checking bench for fill_rect_gen_engine_p.
module tb_fill_rect_gen_engine_p;
    logic clk, rst_, start_strobe, cmd_mode, busy, done, arb_out_rts, arb_in_rtr, arb_out_op;
    logic [15:0] init_addr, cmd_hgt, cmd_wid, arb_out_addr;
    logic [3:0] cmd_rval, cmd_gval, cmd_bval, arb_out_wben;
    logic [31:0] arb_out_data;

    fill_rect_gen_engine_p dut (
        .clk(clk), .rst_(rst_), .start_strobe(start_strobe), .init_addr(init_addr),
        .cmd_hgt(cmd_hgt), .cmd_wid(cmd_wid), .cmd_rval(cmd_rval), .cmd_gval(cmd_gval),
        .cmd_bval(cmd_bval), .cmd_mode(cmd_mode), .busy(busy), .done(done),
        .arb_out_rts(arb_out_rts), .arb_in_rtr(arb_in_rtr), .arb_out_op(arb_out_op),
        .arb_out_addr(arb_out_addr), .arb_out_wben(arb_out_wben), .arb_out_data(arb_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [15:0] qa[$];
    logic [3:0] qw[$];
    logic [31:0] qd[$];
    int done_cyc, last_xfc, stall_bad, rts_cnt;
    bit done_seen;

    // Issues one command and records every transfer until done (bounded).
    task automatic run(input bit rnd, input bit poke, input logic [15:0] a, h, w,
                       input logic [3:0] r, g, b, input logic m);
        logic stalled;
        logic [15:0] pa;
        logic [3:0] pw;
        logic [31:0] pd;
        stalled = 1'b0;
        pa = '0; pw = '0; pd = '0;
        qa.delete(); qw.delete(); qd.delete();
        done_seen = 0; done_cyc = -1; last_xfc = -1; stall_bad = 0; rts_cnt = 0;
        @(negedge clk);
        init_addr = a; cmd_hgt = h; cmd_wid = w;
        cmd_rval = r; cmd_gval = g; cmd_bval = b; cmd_mode = m;
        start_strobe = 1'b1;
        @(negedge clk);
        start_strobe = 1'b0;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            if (poke) begin
                start_strobe = (c == 2);
                if (c == 2) begin
                    init_addr = 16'h0555; cmd_hgt = 16'd1; cmd_wid = 16'd1; cmd_rval = 4'hf;
                end
            end
            if (done) begin
                done_seen = 1; done_cyc = c;
            end else begin
                arb_in_rtr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (stalled && (!arb_out_rts || arb_out_addr !== pa || arb_out_wben !== pw || arb_out_data !== pd))
                    stall_bad++;
                if (arb_out_rts) rts_cnt++;
                if (arb_out_rts && arb_in_rtr) begin
                    qa.push_back(arb_out_addr); qw.push_back(arb_out_wben); qd.push_back(arb_out_data);
                    last_xfc = c;
                end
                stalled = arb_out_rts && !arb_in_rtr;
                pa = arb_out_addr; pw = arb_out_wben; pd = arb_out_data;
                @(negedge clk);
            end
        end
        start_strobe = 1'b0;
        arb_in_rtr = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++; if ({busy, done, arb_out_rts, arb_out_op} !== 4'b0001) $display("FAIL reset_ctl got %b exp 0001", {busy, done, arb_out_rts, arb_out_op}); else n_pass++;
        n_chk++; if (arb_out_addr !== 16'h0) $display("FAIL reset_addr got %h exp 0000", arb_out_addr); else n_pass++;
        n_chk++; if ({arb_out_wben, arb_out_data} !== 36'h0) $display("FAIL reset_wben_data got %h/%h exp 0/0", arb_out_wben, arb_out_data); else n_pass++;
        rst_ = 1'b1;
        @(negedge clk);
        n_chk++; if ({busy, done, arb_out_rts} !== 3'b000) $display("FAIL idle_ctl got %b exp 000", {busy, done, arb_out_rts}); else n_pass++;
    endtask

    task automatic test_1x1;
        logic [15:0] ea[3] = '{16'h100, 16'h101, 16'h102};
        logic [31:0] ed[3] = '{32'h33, 32'h55, 32'h99};
        run(0, 0, 16'h0100, 16'd1, 16'd1, 4'd3, 4'd5, 4'd9, 1'b0);
        n_chk++; if (qa.size() != 3) $display("FAIL 1x1_count got %0d exp 3", qa.size()); else n_pass++;
        for (int i = 0; i < 3 && i < qa.size(); i++) begin
            n_chk++;
            if (qa[i] !== ea[i] || qw[i] !== 4'b0001 || qd[i] !== ed[i])
                $display("FAIL 1x1_xfer%0d got %h/%b/%h exp %h/0001/%h", i, qa[i], qw[i], qd[i], ea[i], ed[i]);
            else n_pass++;
        end
        n_chk++; if (!done_seen || done_cyc != last_xfc + 1) $display("FAIL 1x1_done_lat got %0d exp %0d", done_cyc, last_xfc + 1); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL 1x1_busy_in_done got %b exp 1", busy); else n_pass++;
        @(negedge clk);
        n_chk++; if ({done, busy} !== 2'b00) $display("FAIL 1x1_done_pulse got %b exp 00", {done, busy}); else n_pass++;
    endtask

    task automatic test_1x6;
        logic [15:0] ea[6] = '{16'd3, 16'd4, 16'd5, 16'd3, 16'd4, 16'd5};
        logic [3:0] ew[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
        logic [31:0] ed[6] = '{32'h33, 32'h55, 32'h99, 32'h3300, 32'h5500, 32'h9900};
        run(0, 0, 16'h0000, 16'd1, 16'd6, 4'd3, 4'd5, 4'd9, 1'b0);
        n_chk++; if (qa.size() != 18) $display("FAIL 1x6_count got %0d exp 18", qa.size()); else n_pass++;
        for (int i = 0; i < 6 && 12 + i < qa.size(); i++) begin
            n_chk++;
            if (qa[12+i] !== ea[i] || qw[12+i] !== ew[i] || qd[12+i] !== ed[i])
                $display("FAIL 1x6_xfer%0d got %h/%b/%h exp %h/%b/%h", 12 + i, qa[12+i], qw[12+i], qd[12+i], ea[i], ew[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_3x2;
        int idx[4] = '{6, 9, 12, 17};
        logic [15:0] ea[4] = '{16'h100, 16'h100, 16'h1F0, 16'h1F2};
        logic [3:0] ew[4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        run(0, 0, 16'h0010, 16'd3, 16'd2, 4'd1, 4'd2, 4'd4, 1'b0);
        n_chk++; if (qa.size() != 18) $display("FAIL 3x2_count got %0d exp 18", qa.size()); else n_pass++;
        for (int i = 0; i < 4 && idx[i] < qa.size(); i++) begin
            n_chk++;
            if (qa[idx[i]] !== ea[i] || qw[idx[i]] !== ew[i])
                $display("FAIL 3x2_xfer%0d got %h/%b exp %h/%b", idx[i], qa[idx[i]], qw[idx[i]], ea[i], ew[i]);
            else n_pass++;
        end
    endtask

    task automatic test_outline;
        int pr[12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
        int pc[12] = '{0, 1, 2, 3, 0, 3, 0, 3, 0, 1, 2, 3};
        logic [15:0] ea;
        logic [3:0] ew;
        run(0, 0, 16'h0000, 16'd4, 16'd4, 4'd7, 4'd8, 4'd6, 1'b1);
        n_chk++; if (qa.size() != 36) $display("FAIL outline_count got %0d exp 36", qa.size()); else n_pass++;
        for (int i = 0; i < 12 && 3 * i + 2 < qa.size(); i++) begin
            ea = 16'(pr[i] * 240);
            ew = 4'b0001 << pc[i];
            n_chk++;
            if (qa[3*i] !== ea || qw[3*i] !== ew || qa[3*i+2] !== ea + 16'd2)
                $display("FAIL outline_pix%0d got %h/%b exp %h/%b", i, qa[3*i], qw[3*i], ea, ew);
            else n_pass++;
        end
    endtask

    task automatic check_1x6_model(input string tag);
        logic [15:0] ea;
        logic [3:0] ew, v;
        logic [31:0] ed;
        int p, k, bad;
        bad = 0;
        n_chk++; if (qa.size() != 18) $display("FAIL %s_count got %0d exp 18", tag, qa.size()); else n_pass++;
        for (int t = 0; t < qa.size(); t++) begin
            p = t / 3; k = t % 3;
            v = k == 0 ? 4'd3 : k == 1 ? 4'd5 : 4'd9;
            ea = 16'(3 * (p / 4) + k);
            ew = 4'b0001 << (p % 4);
            ed = {24'd0, v, v} << (8 * (p % 4));
            if (qa[t] !== ea || qw[t] !== ew || qd[t] !== ed) begin
                if (bad == 0) $display("FAIL %s_xfer%0d got %h/%b/%h exp %h/%b/%h", tag, t, qa[t], qw[t], qd[t], ea, ew, ed);
                bad++;
            end
        end
        n_chk++; if (bad != 0) $display("FAIL %s_seq got %0d bad exp 0", tag, bad); else n_pass++;
    endtask

    task automatic test_stall;
        run(1, 0, 16'h0000, 16'd1, 16'd6, 4'd3, 4'd5, 4'd9, 1'b0);
        check_1x6_model("stall");
        n_chk++; if (stall_bad != 0) $display("FAIL stall_stable got %0d exp 0", stall_bad); else n_pass++;
        n_chk++; if (rts_cnt <= 18) $display("FAIL stall_exercised got %0d exp >18", rts_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        run(0, 1, 16'h0000, 16'd1, 16'd6, 4'd3, 4'd5, 4'd9, 1'b0);
        check_1x6_model("ignore_start");
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_idle got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_zero;
        run(0, 0, 16'h0040, 16'd3, 16'd0, 4'd1, 4'd1, 4'd1, 1'b0);
        n_chk++; if (rts_cnt != 0 || qa.size() != 0) $display("FAIL zero_wid_rts got %0d exp 0", rts_cnt); else n_pass++;
        n_chk++; if (!done_seen || done_cyc != 0) $display("FAIL zero_wid_done got %0d exp 0", done_cyc); else n_pass++;
        @(negedge clk);
        run(0, 0, 16'h0040, 16'd0, 16'd5, 4'd1, 4'd1, 4'd1, 1'b1);
        n_chk++; if (rts_cnt != 0 || !done_seen || done_cyc != 0) $display("FAIL zero_hgt got %0d/%0d exp 0/0", rts_cnt, done_cyc); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        init_addr = 16'h0010; cmd_hgt = 16'd3; cmd_wid = 16'd2; cmd_mode = 1'b0;
        start_strobe = 1'b1;
        @(negedge clk);
        start_strobe = 1'b0;
        arb_in_rtr = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++; if (arb_out_rts !== 1'b1) $display("FAIL mid_pre_rts got %b exp 1", arb_out_rts); else n_pass++;
        #2 rst_ = 1'b0;
        #1;
        n_chk++; if ({arb_out_rts, busy, done} !== 3'b000 || arb_out_addr !== 16'h0 || arb_out_wben !== 4'h0)
            $display("FAIL mid_reset got %b/%h/%b exp 000/0000/0000", {arb_out_rts, busy, done}, arb_out_addr, arb_out_wben);
        else n_pass++;
        arb_in_rtr = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        run(0, 0, 16'h0100, 16'd1, 16'd1, 4'd3, 4'd5, 4'd9, 1'b0);
        n_chk++; if (qa.size() != 3 || qa[0] !== 16'h100 || qa[2] !== 16'h102 || qd[2] !== 32'h99)
            $display("FAIL mid_rerun got %0d xfers exp 3 at 100..102", qa.size());
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        rst_ = 1'b0; start_strobe = 1'b0; arb_in_rtr = 1'b0; cmd_mode = 1'b0;
        init_addr = '0; cmd_hgt = '0; cmd_wid = '0; cmd_rval = '0; cmd_gval = '0; cmd_bval = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_1x1;
        test_1x6;
        test_3x2;
        test_outline;
        test_stall;
        test_back_to_back;
        test_zero;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
